// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : Round-robin arbiter sharing one resource among 8 requesters.
//                A grant is held while its requester keeps req high. If others
//                are waiting, the grant is forcibly removed after MAX_HOLD
//                cycles. One dead cycle always separates consecutive grants.
//
//  Ports       : clk        system clock, rising edge
//                rst        asynchronous, active-high reset
//                req[7:0]   request vector, bit i held high by requester i
//                gnt[7:0]   registered one-hot grant, all-zero when idle
//                gnt_idx    registered index of the current or last grantee
//                gnt_valid  high while a grant is active (OR of gnt)
//                preempt    one-cycle pulse when a grant is forcibly removed
//
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_grant = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;

    // Preemption is disabled entirely when MAX_HOLD is zero; the hold
    // counter then parks at zero.
    localparam logic              c_preempt_en = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] c_hold_max   =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    logic [1:0]        r_state;
    logic [2:0]        r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [2:0] w_win;
    logic [2:0] w_cand;
    logic       w_any;
    logic       w_others;

    // Circular priority search starting at r_ptr. The loop runs from the
    // farthest offset down to offset 0 so the closest requester is the
    // last (and therefore winning) assignment.
    always_comb begin
        w_win  = r_ptr;
        w_cand = '0;
        w_any  = |req;
        for (int i = 7; i >= 0; i--) begin
            w_cand = r_ptr + 3'(i);
            if (req[w_cand]) begin
                w_win = w_cand;
            end
        end
    end

    // While granted, gnt is one-hot of gnt_idx, so masking with it leaves
    // only the other requesters.
    assign w_others = |(req & ~gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_ptr      <= 3'd0;
            r_hold_cnt <= '0;
            gnt        <= 8'h00;
            gnt_idx    <= 3'd0;
            gnt_valid  <= 1'b0;
            preempt    <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (r_state)
                c_st_grant: begin
                    if (!req[gnt_idx]) begin
                        // Voluntary release takes precedence over preemption.
                        r_state   <= c_st_gap;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        r_ptr     <= gnt_idx + 3'd1;
                    end else if (c_preempt_en && (r_hold_cnt == c_hold_max) &&
                                 w_others) begin
                        r_state   <= c_st_gap;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        preempt   <= 1'b1;
                        r_ptr     <= gnt_idx + 3'd1;
                    end else if (r_hold_cnt != c_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    // IDLE and GAP both arbitrate; GAP exists only to force
                    // one all-zero cycle between grants.
                    if (w_any) begin
                        r_state    <= c_st_grant;
                        gnt_idx    <= w_win;
                        gnt        <= 8'h01 << w_win;
                        gnt_valid  <= 1'b1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_state   <= c_st_idle;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8
//  Description : Self-checking bench for rr_arbiter8. Vectors of
//                {rst, req, expected outputs} are applied one per clock;
//                expectations go through a scoreboard queue and are compared
//                one cycle after being driven. A hand-written sequence covers
//                asynchronous reset in the middle of a grant.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter8;

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        logic [7:0] egnt;
        logic [2:0] eidx;
        logic       epre;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_vec;
    int n_fail;

    vec_t        vecs[$];
    logic [12:0] sb[$];

    rr_arbiter8 #(
        .MAX_HOLD (16),
        .HOLD_W   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic [7:0] rq,
                                input logic [7:0] g, input logic [2:0] i,
                                input logic p);
        vec_t v;
        v.rst  = r;
        v.req  = rq;
        v.egnt = g;
        v.eidx = i;
        v.epre = p;
        vecs.push_back(v);
    endfunction

    function automatic logic [12:0] pack_exp(input logic [7:0] g,
                                             input logic [2:0] i,
                                             input logic p);
        return {g, i, |g, p};
    endfunction

    task automatic check(input string name, input int n,
                         input logic [12:0] exp);
        logic [12:0] got;
        got = {gnt, gnt_idx, gnt_valid, preempt};
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got gnt=%h idx=%0d valid=%b preempt=%b, want gnt=%h idx=%0d valid=%b preempt=%b",
                     name, n, got[12:5], got[4:2], got[1], got[0],
                     exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if ((gnt_valid !== (|gnt)) || !$onehot0(gnt) ||
            (gnt_valid && (gnt !== (8'h01 << gnt_idx)))) begin
            n_fail++;
            $display("FAIL invariant: gnt=%h idx=%0d valid=%b", gnt, gnt_idx, gnt_valid);
        end
    end

    initial begin
        logic [7:0] oh;
        n_vec  = 0;
        n_fail = 0;
        rst    = 1'b1;
        req    = 8'h00;

        // ---------------- vector table ----------------
        // Sole requester held 40 cycles: no preemption, then release.
        // Pointer is 6 here (left by the reset sequence below).
        for (int c = 0; c < 40; c++) add(1'b0, 8'h08, 8'h08, 3'd3, 1'b0);
        add(1'b0, 8'h00, 8'h00, 3'd3, 1'b0);
        add(1'b0, 8'h00, 8'h00, 3'd3, 1'b0);
        // Pointer wrap: 7 releases while 0 and 7 both request in the gap.
        add(1'b0, 8'h80, 8'h80, 3'd7, 1'b0);
        add(1'b0, 8'h81, 8'h80, 3'd7, 1'b0);
        add(1'b0, 8'h01, 8'h00, 3'd7, 1'b0);
        add(1'b0, 8'h81, 8'h01, 3'd0, 1'b0);
        add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        // Synchronous-looking reset pulse to bring the pointer back to 0.
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);
        // Rotation: all request, each grantee drops after 2 cycles.
        for (int k = 0; k < 8; k++) begin
            oh = 8'h01 << k;
            add(1'b0, 8'hFF, oh, 3'(k), 1'b0);
            add(1'b0, 8'hFF, oh, 3'(k), 1'b0);
            add(1'b0, 8'hFF & ~oh, 8'h00, 3'(k), 1'b0);
        end
        // Wrap back to 0, then preemption after 16 grant cycles.
        for (int c = 0; c < 16; c++) add(1'b0, 8'h03, 8'h01, 3'd0, 1'b0);
        add(1'b0, 8'h03, 8'h00, 3'd0, 1'b1);
        add(1'b0, 8'h03, 8'h02, 3'd1, 1'b0);
        add(1'b0, 8'h01, 8'h00, 3'd1, 1'b0);
        // Release/preempt tie on the 16th grant cycle: release wins.
        for (int c = 0; c < 16; c++) add(1'b0, 8'h03, 8'h01, 3'd0, 1'b0);
        add(1'b0, 8'h02, 8'h00, 3'd0, 1'b0);
        add(1'b0, 8'h02, 8'h02, 3'd1, 1'b0);
        add(1'b0, 8'h00, 8'h00, 3'd1, 1'b0);
        add(1'b0, 8'h00, 8'h00, 3'd1, 1'b0);

        // ---------------- reset state ----------------
        #1;
        check("reset", 0, pack_exp(8'h00, 3'd0, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        // ---------------- async reset mid-grant ----------------
        req = 8'h20;
        @(posedge clk); #1;
        check("mid_grant_a", 0, pack_exp(8'h20, 3'd5, 1'b0));
        @(posedge clk); #1;
        check("mid_grant_b", 0, pack_exp(8'h20, 3'd5, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 0, pack_exp(8'h00, 3'd0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("regrant", 0, pack_exp(8'h20, 3'd5, 1'b0));
        @(negedge clk);
        req = 8'h00;
        @(posedge clk); #1;
        check("release_gap", 0, pack_exp(8'h00, 3'd5, 1'b0));
        @(negedge clk);
        @(posedge clk); #1;
        check("idle", 0, pack_exp(8'h00, 3'd5, 1'b0));

        // ---------------- table run through the scoreboard ----------------
        foreach (vecs[n]) begin
            @(negedge clk);
            rst = vecs[n].rst;
            req = vecs[n].req;
            sb.push_back(pack_exp(vecs[n].egnt, vecs[n].eidx, vecs[n].epre));
            @(posedge clk); #1;
            check("vec", n, sb.pop_front());
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Registers a 3-bit grant index and produces the matching one-hot grant vector, using the same 3-to-8 one-hot encoding as the team's decoder: idx 3'b000 gives 8'b00000001, and so on.
- Supports grant hold, fairness rotation and optional forced preemption after a maximum hold time.
- Sits between bus/resource clients and the shared datapath select logic.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles before preemption when another requester is waiting. 0 disables preemption.
- HOLD_W, 5: hold counter width. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector. Bit i is held high by requester i while it wants or uses the resource.
- gnt  output  8  registered one-hot grant, all-zero when idle.
- gnt_idx  output  3  registered index of the current or last grantee.
- gnt_valid  output  1  high while any grant is active. Equals OR of gnt.
- preempt  output  1  one-cycle pulse in the cycle a grant is forcibly removed.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, preempt=0.
  - Internal priority pointer ptr=3'd0, hold_cnt=0, state=IDLE.
- States: IDLE, GRANT, GAP.
- Arbitration (evaluated in IDLE and GAP):
  - Winner = first i with req[i]=1, searching circularly ptr, ptr+1, ..., ptr+7 (mod 8).
  - If any req: on the next edge go to GRANT, gnt_idx=winner, gnt=one-hot(winner), gnt_valid=1, hold_cnt=0.
  - If no req: go to (or stay in) IDLE with outputs zero.
- Latency: a req sampled high at edge N in IDLE shows gnt high after edge N (one registered cycle). No combinational path from req to gnt.
- GRANT, evaluated each edge in this priority order:
  - Release: req[gnt_idx]=0 -> GAP. gnt=0, gnt_valid=0, ptr=gnt_idx+1 (3-bit wrap, 7 goes to 0). gnt_idx keeps its value.
  - Preempt: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and any other req bit set -> GAP, preempt=1 for that one cycle, gnt=0, ptr=gnt_idx+1.
  - Otherwise: stay in GRANT. hold_cnt increments, saturating at MAX_HOLD-1.
- Sole requester: with no other requester pending, the grant is held indefinitely; there is no preemption even at the hold limit.
- GAP:
  - Exactly one dead cycle with gnt all-zero between consecutive grants, so grants never overlap.
  - Then arbitrate as above.
  - preempt returns to 0 after its single cycle.
- Invariants:
  - gnt is always zero or exactly one-hot.
  - gnt == one-hot(gnt_idx) whenever gnt_valid=1.
- Simultaneous events: if the grantee drops req in the same cycle the preempt condition would fire, the release wins and preempt stays 0.
- Request deasserted by a non-grantee before being served: no effect, no latching of requests.
- Fairness: with all 8 requesting continuously, each is granted once per 8 grant slots.

Test Plan:
- Reset mid-grant: grant idx 5 active, assert rst between edges -> gnt=0, gnt_valid=0, gnt_idx=0 immediately. After release, req=8'h20 -> gnt=8'h20 one edge later.
- Single requester: req=8'h08 held 40 cycles, MAX_HOLD=16 -> gnt=8'h08 for all 40 cycles, preempt never 1. Drop req -> gnt=0 next edge.
- Rotation: req=8'hFF held, each requester drops its req after 2 grant cycles and re-raises it after the GAP -> grant order 0,1,...,7,0, with exactly one zero cycle between grants.
- Pointer wrap: grant 7 released with req=8'h81 pending -> next grant is idx 0 (gnt=8'h01), not 7.
- Preemption: req=8'h03, requester 0 holds -> gnt=8'h01 for exactly 16 cycles, then preempt=1 for 1 cycle with gnt=0, then gnt=8'h02.
- Release/preempt tie: requester 0 drops req on the 16th grant cycle with req[1]=1 -> preempt stays 0, GAP, then gnt=8'h02.
